seg7_to_bcd_reader: RTL and testbench
=====================================

// Module: seg7_to_bcd_reader
// PURPOSE
//  Inverse of our BCD-to-7-segment decoder: observes the segment and digit-enable lines of a
//  multiplexed 7-segment display and recovers the BCD value shown on each digit.
//  Segment/enable inputs are asynchronous to clk, so they are synchronised first.
//  A sample is decoded only after it has been stable for STABLE_CNT clocks.
//  Results are reported one at a time over a valid/ready handshake, with blank and error flags.
// PARAMETERS
//  NUM_DIGITS  4  number of multiplexed digits (digit_en width), >=1
//  STABLE_CNT  3  consecutive identical synchronised samples required before reporting, >=1
//  IDX_W       2  width of digit_idx, = max(1,$clog2(NUM_DIGITS))
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  seg_in     in   7           segments {a,b,c,d,e,f,g}, bit6=a, 1=lit; asynchronous
//  digit_en   in   NUM_DIGITS  digit enables, active-high, one-hot when valid; asynchronous
//  out_valid  out  1           report pending; held until accepted
//  out_ready  in   1           consumer accepts the report when out_valid&&out_ready
//  bcd_out    out  4           decoded digit 0..9; 4'hF if blank or error
//  digit_idx  out  IDX_W       index of the set digit_en bit
//  blank      out  1           pattern was 7'b0000000
//  pattern_err out 1           pattern is neither blank nor in the table
//  overrun    out  1           1-cycle pulse: a report was dropped because one was pending
// BEHAVIOUR
//  Reset (async, rst_n=0): sync regs, prev, cnt=0; state IDLE; all outputs 0, including digit_idx.
//  Sync: 2-flop synchroniser on {digit_en,seg_in}; the tracker uses only stage-2 value S.
//  Decode table (seg -> bcd), which is exact-match only:
//   1111110->0 0110000->1 1101101->2 1111001->3 0110011->4
//   1011011->5 0011111->6 1110000->7 1111111->8 1110011->9
//  FSM, evaluated every clk:
//   IDLE: S.digit_en not one-hot -> stay, cnt=0. One-hot -> prev<=S, cnt<=1, go TRACK
//     (if STABLE_CNT==1, emit this cycle and go REPORTED).
//   TRACK: S!=prev and S one-hot -> prev<=S, cnt<=1. S not one-hot -> cnt<=0, go IDLE.
//     S==prev -> cnt<=cnt+1. When cnt reaches STABLE_CNT -> emit, go REPORTED.
//   REPORTED: S==prev -> stay, so each stable episode is emitted exactly once.
//     S!=prev -> same action as TRACK on change.
//     S not one-hot -> go IDLE.
//  cnt saturates at STABLE_CNT and never wraps.
//  Emit: if out_valid==0, or out_valid&&out_ready in the same cycle, load bcd_out, digit_idx,
//   blank and pattern_err from prev, and set out_valid=1.
//   Otherwise drop the report, pulse overrun for 1 cycle, and leave the held outputs unchanged.
//  Latency: the input change is captured by sync1 at edge 0. out_valid is seen high after
//   edge STABLE_CNT+1 (edge 4 for the default).
//  Handshake: out_valid&&out_ready with no emit -> out_valid<=0 on that edge.
//   Data outputs hold their last value when out_valid==0. out_ready is ignored when out_valid==0.
//  Blank: blank=1, pattern_err=0, bcd_out=4'hF. Error: pattern_err=1, blank=0, bcd_out=4'hF.
//  digit_idx: binary index of the single set bit of prev.digit_en.
//  Reset mid-operation: pending report lost; all state returns to reset values immediately.
// TESTING
//  1 Reset: rst_n=0 with random inputs -> all outputs 0. Release -> no out_valid while digit_en=0.
//  2 Basic: digit_en=4'b0100, seg=7'b1101101 held, out_ready=1
//    -> out_valid high after edge 4 for 1 cycle; bcd_out=2, digit_idx=2, flags 0; no re-report.
//  3 Glitch filter: seg toggles 1111001/0110000 every 2 clocks (STABLE_CNT=3) -> no out_valid.
//    Then hold 0110000 -> one report, bcd_out=1.
//  4 Flags: seg=0000000 -> blank=1, bcd_out=F. seg=1010101 -> pattern_err=1, bcd_out=F.
//    digit_en=4'b0011 -> no report.
//  5 Backpressure: out_ready=0; report digit 0 value 5, then digit 1 value 7
//    -> overrun pulses once; outputs still show 5/idx0. out_ready=1 -> accepted, out_valid drops.
//  6 Scan: cycle digits 0..3 showing 9,8,0,6, with 6 clocks per digit
//    -> four reports in order with correct idx/bcd; then rst_n pulse mid-scan -> outputs 0.

Source files
------------

// File: rtl/seg7_to_bcd_reader.sv
// seg7_to_bcd_reader
// Watches the segment and digit-enable lines of a multiplexed 7-segment display
// and recovers the BCD value shown on each digit. Inputs are synchronised and
// must stay unchanged for STABLE_CNT clocks before a report is produced. Reports
// leave one at a time over a valid/ready handshake, with blank and error flags.

module seg7_to_bcd_reader #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3,
  parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            bcd_out,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  blank,
  output logic                  pattern_err,
  output logic                  overrun
);

  // One sample is the digit enables on top of the seven segment bits.
  localparam int SAMPLE_W = NUM_DIGITS + 7;
  localparam int CNT_W    = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // With a one-clock stability window a fresh sample is reported immediately.
  localparam bit EMIT_ON_FIRST = (STABLE_CNT == 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    REPORTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] bcd;
    logic       is_blank;
    logic       is_err;
  } decode_t;

  logic [SAMPLE_W-1:0]   sync1;
  logic [SAMPLE_W-1:0]   sync2;
  logic [SAMPLE_W-1:0]   prev;
  logic [SAMPLE_W-1:0]   prev_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [CNT_W-1:0]      cnt_inc;
  state_t                state;
  state_t                state_next;
  state_t                restart_state;
  logic                  emit;
  logic                  s_one_hot;
  logic                  s_same;
  logic [NUM_DIGITS-1:0] s_en;
  logic [NUM_DIGITS-1:0] prev_en_next;
  decode_t               dec;
  logic [IDX_W-1:0]      idx_next;

  // True when exactly one digit enable is set.
  function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) begin
        ones++;
      end
    end
    return (ones == 1);
  endfunction

  // Binary index of the (single) set enable bit; zero if none is set.
  function automatic logic [IDX_W-1:0] encode_idx(input logic [NUM_DIGITS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Exact-match segment decode; anything not in the table and not dark is an error.
  function automatic decode_t decode_seg(input logic [6:0] seg);
    decode_t d;
    d.bcd      = 4'hF;
    d.is_blank = 1'b0;
    d.is_err   = 1'b0;
    case (seg)
      7'b1111110: d.bcd = 4'd0;
      7'b0110000: d.bcd = 4'd1;
      7'b1101101: d.bcd = 4'd2;
      7'b1111001: d.bcd = 4'd3;
      7'b0110011: d.bcd = 4'd4;
      7'b1011011: d.bcd = 4'd5;
      7'b0011111: d.bcd = 4'd6;
      7'b1110000: d.bcd = 4'd7;
      7'b1111111: d.bcd = 4'd8;
      7'b1110011: d.bcd = 4'd9;
      7'b0000000: d.is_blank = 1'b1;
      default:    d.is_err   = 1'b1;
    endcase
    return d;
  endfunction

  assign s_en          = sync2[SAMPLE_W-1:7];
  assign s_one_hot     = is_one_hot(s_en);
  assign s_same        = (sync2 == prev);
  assign cnt_inc       = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  assign restart_state = EMIT_ON_FIRST ? REPORTED : TRACK;

  // Two-flop synchroniser for the asynchronous display lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {digit_en, seg_in};
      sync2 <= sync1;
    end
  end

  // State, last seen sample and stability counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prev  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      prev  <= prev_next;
      cnt   <= cnt_next;
    end
  end

  // Stability tracking: a sample that changes restarts the count, a non one-hot
  // enable drops back to idle, and each stable episode emits exactly once.
  always_comb begin
    state_next = state;
    prev_next  = prev;
    cnt_next   = cnt;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        if (s_one_hot) begin
          prev_next  = sync2;
          cnt_next   = CNT_ONE;
          state_next = restart_state;
          emit       = EMIT_ON_FIRST;
        end else begin
          cnt_next = '0;
        end
      end
      TRACK: begin
        if (!s_one_hot) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (!s_same) begin
          prev_next  = sync2;
          cnt_next   = CNT_ONE;
          state_next = restart_state;
          emit       = EMIT_ON_FIRST;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            emit       = 1'b1;
            state_next = REPORTED;
          end
        end
      end
      REPORTED: begin
        if (!s_one_hot) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (!s_same) begin
          prev_next  = sync2;
          cnt_next   = CNT_ONE;
          state_next = restart_state;
          emit       = EMIT_ON_FIRST;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Decode the sample being reported; prev_next equals the stable sample on an emit.
  always_comb begin
    prev_en_next = prev_next[SAMPLE_W-1:7];
    dec          = decode_seg(prev_next[6:0]);
    idx_next     = encode_idx(prev_en_next);
  end

  // Report handshake: load on emit if the slot is free or being freed, otherwise
  // drop the report and flag an overrun; the held data stays put while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      bcd_out     <= 4'h0;
      digit_idx   <= '0;
      blank       <= 1'b0;
      pattern_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (emit) begin
        if (!out_valid || out_ready) begin
          out_valid   <= 1'b1;
          bcd_out     <= dec.bcd;
          digit_idx   <= idx_next;
          blank       <= dec.is_blank;
          pattern_err <= dec.is_err;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_to_bcd_reader.sv
// tb_seg7_to_bcd_reader
// Directed and randomized stimulus for the 7-segment reader, checked every cycle
// against a reference model built from run lengths of the delayed input stream.

module tb_seg7_to_bcd_reader;

  localparam int NUM_DIGITS = 4;
  localparam int STABLE_CNT = 3;
  localparam int IDX_W      = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       seg_in;
  logic [3:0]       digit_en;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       bcd_out;
  logic [IDX_W-1:0] digit_idx;
  logic             blank;
  logic             pattern_err;
  logic             overrun;

  seg7_to_bcd_reader #(
    .NUM_DIGITS(NUM_DIGITS),
    .STABLE_CNT(STABLE_CNT),
    .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .digit_en(digit_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bcd_out(bcd_out),
    .digit_idx(digit_idx),
    .blank(blank),
    .pattern_err(pattern_err),
    .overrun(overrun)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Segment patterns for digits 0..9.
  logic [6:0] seg_table [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1110011
  };

  // Reference model state.
  logic [10:0] hist [$];
  logic [10:0] last_s;
  int          run;
  logic        m_valid;
  logic [3:0]  m_bcd;
  logic [1:0]  m_idx;
  logic        m_blank;
  logic        m_err;
  logic        m_ovr;

  // Observed handshakes and overruns.
  int          acc_count;
  int          acc_bcd [$];
  int          acc_idx [$];
  logic        last_acc_blank;
  logic        last_acc_err;
  int          ovr_seen;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void model_reset();
    hist    = {11'd0, 11'd0};
    last_s  = '0;
    run     = 0;
    m_valid = 1'b0;
    m_bcd   = 4'h0;
    m_idx   = 2'd0;
    m_blank = 1'b0;
    m_err   = 1'b0;
    m_ovr   = 1'b0;
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  function automatic void model_edge();
    logic [10:0] s;
    logic        onehot;
    logic        emit;
    int          found;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = hist.pop_front();
    hist.push_back({digit_en, seg_in});
    onehot = ($countones(s[10:7]) == 1);
    if (!onehot) run = 0;
    else if (s == last_s && run > 0) run = (run > STABLE_CNT) ? run : run + 1;
    else run = 1;
    last_s = s;
    emit   = (run == STABLE_CNT);
    m_ovr  = 1'b0;
    if (emit) begin
      if (!m_valid || out_ready) begin
        found = -1;
        for (int i = 0; i < 10; i++) if (seg_table[i] == s[6:0]) found = i;
        m_blank = (s[6:0] == 7'd0);
        m_err   = !m_blank && (found < 0);
        m_bcd   = (found < 0) ? 4'hF : 4'(found);
        for (int i = 0; i < 4; i++) if (s[7+i]) m_idx = 2'(i);
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic compare_all();
    check_output("out_valid", 32'(out_valid), 32'(m_valid));
    check_output("bcd_out", 32'(bcd_out), 32'(m_bcd));
    check_output("digit_idx", 32'(digit_idx), 32'(m_idx));
    check_output("blank", 32'(blank), 32'(m_blank));
    check_output("pattern_err", 32'(pattern_err), 32'(m_err));
    check_output("overrun", 32'(overrun), 32'(m_ovr));
    if (overrun === 1'b1) ovr_seen++;
  endtask

  // One clock: log any handshake about to happen, step model, then compare.
  task automatic tick(input int n);
    repeat (n) begin
      if (rst_n && out_valid === 1'b1 && out_ready) begin
        acc_count++;
        acc_bcd.push_back(int'(bcd_out));
        acc_idx.push_back(int'(digit_idx));
        last_acc_blank = blank;
        last_acc_err   = pattern_err;
      end
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] en, input logic [6:0] seg,
                                input logic ready, input int n);
    digit_en  = en;
    seg_in    = seg;
    out_ready = ready;
    tick(n);
  endtask

  initial begin
    int base;
    int ovr_base;
    logic [3:0] en;
    logic [6:0] seg;
    int hold;
    acc_count      = 0;
    ovr_seen       = 0;
    last_acc_blank = 1'b0;
    last_acc_err   = 1'b0;

    // Reset with random inputs: every output must read zero.
    rst_n     = 1'b0;
    digit_en  = 4'($urandom);
    seg_in    = 7'($urandom);
    out_ready = 1'($urandom);
    model_reset();
    #1;
    compare_all();
    tick(3);
    digit_en = 4'b0000;
    rst_n    = 1'b1;
    apply_stimulus(4'b0000, 7'($urandom), 1'b1, 6);

    // Basic report of digit 2 showing '2'.
    base = acc_count;
    apply_stimulus(4'b0100, 7'b1101101, 1'b1, 10);
    check_output("basic_reports", 32'(acc_count - base), 32'd1);
    check_output("basic_bcd", 32'(acc_bcd[acc_bcd.size()-1]), 32'd2);
    check_output("basic_idx", 32'(acc_idx[acc_idx.size()-1]), 32'd2);
    apply_stimulus(4'b0000, 7'b0, 1'b1, 4);

    // Glitch filter: flicker between 3 and 1 every two clocks, then settle on 1.
    base = acc_count;
    for (int k = 0; k < 8; k++)
      apply_stimulus(4'b0001, (k % 2) ? 7'b0110000 : 7'b1111001, 1'b1, 2);
    check_output("glitch_reports", 32'(acc_count - base), 32'd0);
    apply_stimulus(4'b0001, 7'b0110000, 1'b1, 8);
    check_output("settle_reports", 32'(acc_count - base), 32'd1);
    check_output("settle_bcd", 32'(acc_bcd[acc_bcd.size()-1]), 32'd1);
    apply_stimulus(4'b0000, 7'b0, 1'b1, 4);

    // Blank, error and non one-hot enables.
    apply_stimulus(4'b0001, 7'b0000000, 1'b1, 8);
    check_output("blank_bcd", 32'(acc_bcd[acc_bcd.size()-1]), 32'hF);
    check_output("blank_flag", 32'(last_acc_blank), 32'd1);
    apply_stimulus(4'b0001, 7'b1010101, 1'b1, 8);
    check_output("err_bcd", 32'(acc_bcd[acc_bcd.size()-1]), 32'hF);
    check_output("err_flag", 32'(last_acc_err), 32'd1);
    base = acc_count;
    apply_stimulus(4'b0011, 7'b1111111, 1'b1, 8);
    check_output("multi_en_reports", 32'(acc_count - base), 32'd0);
    apply_stimulus(4'b0000, 7'b0, 1'b1, 4);

    // Backpressure: second report is dropped while the first is held.
    ovr_base = ovr_seen;
    apply_stimulus(4'b0001, 7'b1011011, 1'b0, 6);
    apply_stimulus(4'b0010, 7'b1110000, 1'b0, 6);
    check_output("bp_overruns", 32'(ovr_seen - ovr_base), 32'd1);
    check_output("bp_valid", 32'(out_valid), 32'd1);
    check_output("bp_bcd", 32'(bcd_out), 32'd5);
    check_output("bp_idx", 32'(digit_idx), 32'd0);
    base = acc_count;
    apply_stimulus(4'b0010, 7'b1110000, 1'b1, 1);
    check_output("bp_accept", 32'(acc_count - base), 32'd1);
    check_output("bp_drop_valid", 32'(out_valid), 32'd0);
    apply_stimulus(4'b0000, 7'b0, 1'b1, 4);

    // Scan digits 0..3 showing 9, 8, 0, 6.
    base = acc_count;
    apply_stimulus(4'b0001, seg_table[9], 1'b1, 6);
    apply_stimulus(4'b0010, seg_table[8], 1'b1, 6);
    apply_stimulus(4'b0100, seg_table[0], 1'b1, 6);
    apply_stimulus(4'b1000, seg_table[6], 1'b1, 6);
    apply_stimulus(4'b0000, 7'b0, 1'b1, 3);
    check_output("scan_reports", 32'(acc_count - base), 32'd4);
    if (acc_count - base == 4) begin
      check_output("scan_bcd0", 32'(acc_bcd[base]), 32'd9);
      check_output("scan_bcd1", 32'(acc_bcd[base+1]), 32'd8);
      check_output("scan_bcd2", 32'(acc_bcd[base+2]), 32'd0);
      check_output("scan_bcd3", 32'(acc_bcd[base+3]), 32'd6);
      check_output("scan_idx3", 32'(acc_idx[base+3]), 32'd3);
    end

    // Reset in the middle of a scan, with a report pending.
    apply_stimulus(4'b0001, seg_table[4], 1'b0, 6);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_output("mid_rst_valid", 32'(out_valid), 32'd0);
    check_output("mid_rst_bcd", 32'(bcd_out), 32'd0);
    tick(2);
    rst_n = 1'b1;
    apply_stimulus(4'b0000, 7'b0, 1'b1, 4);

    // Randomized episodes with random backpressure.
    for (int e = 0; e < 300; e++) begin
      if ($urandom_range(0, 3) != 0) en = 4'(1 << $urandom_range(0, 3));
      else en = 4'($urandom);
      case ($urandom_range(0, 19))
        0, 1, 2:    seg = 7'b0;
        3, 4, 5, 6: seg = 7'($urandom);
        default:    seg = seg_table[$urandom_range(0, 9)];
      endcase
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++)
        apply_stimulus(en, seg, ($urandom_range(0, 9) < 7), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
